// File: rtl/text_pkg.sv
// Shared constants for the score-line text overlay: glyph geometry and the
// ASCII codes of the fixed "SCORE:" prefix.
package text_pkg;

  localparam logic [6:0] CH_S     = 7'h53;
  localparam logic [6:0] CH_C     = 7'h43;
  localparam logic [6:0] CH_O     = 7'h4F;
  localparam logic [6:0] CH_R     = 7'h52;
  localparam logic [6:0] CH_E     = 7'h45;
  localparam logic [6:0] CH_COLON = 7'h3A;
  localparam logic [6:0] CH_ZERO  = 7'h30;

  localparam int GLYPH_W      = 8;
  localparam int GLYPH_H      = 16;
  localparam int SCORE_DIGITS = 5;
  localparam int TEXT_CHARS   = 11;

  // ASCII code of a BCD digit.
  function automatic logic [6:0] digit_code(input logic [3:0] d);
    return CH_ZERO + {3'b000, d};
  endfunction

endpackage

// File: rtl/score_text_if.sv
// Bundles the pixel stream, score controls and font ROM bus of the overlay.
// The slave side is the overlay block; the master side is its surroundings.
interface score_text_if;

  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        frame_tick;
  logic        score_inc;
  logic        score_clr;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        text_on;
  logic [19:0] score_bcd;

  modport slave (
    input  pixel_x, pixel_y, video_on, frame_tick, score_inc, score_clr, rom_data,
    output rom_addr, text_on, score_bcd
  );

  modport master (
    output pixel_x, pixel_y, video_on, frame_tick, score_inc, score_clr, rom_data,
    input  rom_addr, text_on, score_bcd
  );

endinterface

// File: rtl/bcd_digit.sv
// One decimal digit of the score counter. Increments on inc_in, wrapping 9->0
// and raising carry_out so the next digit up counts in the same cycle.
module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_in,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] digit_q;

  // Digit register: clear has priority over increment; holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else if (clr) begin
      digit_q <= 4'd0;
    end else if (inc_in) begin
      digit_q <= (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  assign carry_out = inc_in & ~clr & (digit_q == 4'd9);
  assign digit     = digit_q;

endmodule

// File: rtl/score_text.sv
// Draws "SCORE:ddddd" at (TEXT_X, TEXT_Y). Converts the pixel coordinate to a
// font ROM address, realigns the bit column with the one-cycle ROM latency and
// registers the resulting text pixel. Also owns the BCD score counter and the
// per-frame snapshot the text is drawn from, so digits never tear mid-frame.
module score_text
  import text_pkg::*;
#(
  parameter logic [9:0] TEXT_X = 10'd8,
  parameter logic [9:0] TEXT_Y = 10'd8
) (
  input logic         clk,
  input logic         reset,
  score_text_if.slave bus
);

  localparam logic [9:0] X_END = TEXT_X + 10'(GLYPH_W * TEXT_CHARS);
  localparam logic [9:0] Y_END = TEXT_Y + 10'(GLYPH_H);

  logic [4*SCORE_DIGITS-1:0] score_q;
  logic [4*SCORE_DIGITS-1:0] snap_q;
  logic [SCORE_DIGITS:0]     carry_chain;
  logic                      saturated;
  logic                      unused_top_carry;

  logic       in_region;
  logic [9:0] dx;
  logic [6:0] char_idx;
  logic [2:0] bit_col;
  logic [3:0] glyph_row;
  logic [6:0] char_code;

  logic       in_region_d;
  logic [2:0] bit_col_d;
  logic       text_on_q;

  // Score counter: a ripple chain of digits, frozen once every digit reads 9.
  assign saturated      = (score_q == {SCORE_DIGITS{4'h9}});
  assign carry_chain[0] = bus.score_inc & ~saturated;

  for (genvar i = 0; i < SCORE_DIGITS; i++) begin : gen_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .inc_in    (carry_chain[i]),
      .clr       (bus.score_clr),
      .digit     (score_q[4*i +: 4]),
      .carry_out (carry_chain[i+1])
    );
  end

  assign unused_top_carry = carry_chain[SCORE_DIGITS];
  assign bus.score_bcd    = score_q;

  // Snapshot of the score taken at the start of vertical blank; captures the
  // value before any same-cycle increment or clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q <= '0;
    end else if (bus.frame_tick) begin
      snap_q <= score_q;
    end
  end

  assign in_region = bus.video_on
                   & (bus.pixel_x >= TEXT_X) & (bus.pixel_x < X_END)
                   & (bus.pixel_y >= TEXT_Y) & (bus.pixel_y < Y_END);
  assign dx        = bus.pixel_x - TEXT_X;
  assign char_idx  = dx[9:3];
  assign bit_col   = dx[2:0];
  assign glyph_row = bus.pixel_y[3:0] - TEXT_Y[3:0];

  // Character code for the current column: fixed prefix, then snapshot digits
  // most significant first, leading zeros included.
  always_comb begin
    char_code = CH_ZERO;
    case (char_idx)
      7'd0:    char_code = CH_S;
      7'd1:    char_code = CH_C;
      7'd2:    char_code = CH_O;
      7'd3:    char_code = CH_R;
      7'd4:    char_code = CH_E;
      7'd5:    char_code = CH_COLON;
      7'd6:    char_code = digit_code(snap_q[19:16]);
      7'd7:    char_code = digit_code(snap_q[15:12]);
      7'd8:    char_code = digit_code(snap_q[11:8]);
      7'd9:    char_code = digit_code(snap_q[7:4]);
      7'd10:   char_code = digit_code(snap_q[3:0]);
      default: char_code = CH_ZERO;
    endcase
  end

  assign bus.rom_addr = in_region ? {char_code, glyph_row} : 11'h000;

  // Delay the bit column and region flag to line up with the ROM output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_region_d <= 1'b0;
      bit_col_d   <= 3'd0;
    end else begin
      in_region_d <= in_region;
      bit_col_d   <= bit_col;
    end
  end

  // Pick the glyph bit for this column; MSB of the ROM row is the leftmost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      text_on_q <= 1'b0;
    end else begin
      text_on_q <= in_region_d & bus.rom_data[3'd7 - bit_col_d];
    end
  end

  assign bus.text_on = text_on_q;

endmodule
